// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port architectural register file:
// default geometry and ABI register index names.
package regfile_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;

  typedef enum logic [4:0] {
    ZERO = 5'd0,  RA  = 5'd1,  SP  = 5'd2,  GP  = 5'd3,
    TP   = 5'd4,  T0  = 5'd5,  T1  = 5'd6,  T2  = 5'd7,
    S0   = 5'd8,  S1  = 5'd9,  A0  = 5'd10, A1  = 5'd11,
    A2   = 5'd12, A3  = 5'd13, A4  = 5'd14, A5  = 5'd15,
    A6   = 5'd16, A7  = 5'd17, S2  = 5'd18, S3  = 5'd19,
    S4   = 5'd20, S5  = 5'd21, S6  = 5'd22, S7  = 5'd23,
    S8   = 5'd24, S9  = 5'd25, S10 = 5'd26, S11 = 5'd27,
    T3   = 5'd28, T4  = 5'd29, T5  = 5'd30, T6  = 5'd31
  } abi_reg_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: issue allocates a destination, writeback clears it,
// and each read port looks up the current (not next) busy state.
module regfile_scoreboard #(
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS),
  parameter int NRD   = 2,
  parameter int NWR   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_en,
  input  logic [AW-1:0]     alloc_addr,
  input  logic [NWR-1:0]    clr_en,
  input  logic [NWR*AW-1:0] clr_addr,
  input  logic [NRD*AW-1:0] lookup_addr,
  output logic [NRD-1:0]    lookup_busy
);

  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;

  // Allocation is applied after the clears so a same-cycle new producer keeps the bit set.
  always_comb begin
    busy_next = busy_reg;
    for (int j = 0; j < NWR; j++) begin
      if (clr_en[j]) busy_next[clr_addr[j*AW +: AW]] = 1'b0;
    end
    if (alloc_en) busy_next[alloc_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy_reg <= '0;
    else       busy_reg <= busy_next;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_lookup
      assign lookup_busy[gi] = busy_reg[lookup_addr[gi*AW +: AW]];
    end
  endgenerate

endmodule

// File: rtl/arch_regfile_mp.sv
// Parametrised multi-port register file with registered reads and busy scoreboard.
// REGFILE_WR_BYPASS_EN selects write-first forwarding; otherwise colliding reads stall.
module arch_regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = NREGS_DEFAULT,
  parameter int AW    = $clog2(NREGS),
  parameter int NRD   = 2,
  parameter int NWR   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  output logic                rw_conflict
);

  logic [XLEN-1:0] mem_reg [NREGS];
  logic [NRD-1:0]  conflict;

  // Ascending port order makes the highest-indexed write port win on a collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NREGS; k++) mem_reg[k] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] != '0)
          mem_reg[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data_next;
      logic [XLEN-1:0] data_reg;

      assign addr = rd_addr[gi*AW +: AW];

`ifdef REGFILE_WR_BYPASS_EN
      always_comb begin
        data_next = mem_reg[addr];
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j] && wr_addr[j*AW +: AW] == addr)
            data_next = wr_data[j*XLEN +: XLEN];
        end
        if (addr == '0) data_next = '0;
      end
      assign conflict[gi] = 1'b0;
`else
      logic hit;

      always_comb begin
        data_next = mem_reg[addr];
        hit = 1'b0;
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j] && wr_addr[j*AW +: AW] == addr) hit = 1'b1;
        end
        if (addr == '0) begin
          data_next = '0;
          hit = 1'b0;
        end
      end
      assign conflict[gi] = rd_en[gi] & hit;
`endif

      // A stalled port keeps its old data; the decoder reissues the read.
      always_ff @(posedge clk) begin
        if (reset)                             data_reg <= '0;
        else if (rd_en[gi] && !conflict[gi])   data_reg <= data_next;
      end

      assign rd_data[gi*XLEN +: XLEN] = data_reg;
    end
  endgenerate

  assign rw_conflict = |conflict;

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW),
    .NRD   (NRD),
    .NWR   (NWR)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .alloc_en    (alloc_en),
    .alloc_addr  (alloc_addr),
    .clr_en      (wr_en),
    .clr_addr    (wr_addr),
    .lookup_addr (rd_addr),
    .lookup_busy (rd_busy)
  );

endmodule

// File: tb/tb_arch_regfile_mp.sv
// Randomised bench for arch_regfile_mp (NRD=2, NWR=2) against an array-based
// reference model; follows REGFILE_WR_BYPASS_EN the same way the design does.
module tb_arch_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int NWR   = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [NRD-1:0]      rd_en;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                alloc_en;
  logic [AW-1:0]       alloc_addr;
  logic                rw_conflict;

  int n_vec = 0;
  int n_err = 0;

  logic [XLEN-1:0] m_mem  [NREGS];
  logic            m_busy [NREGS];
  logic [XLEN-1:0] m_rdq  [NRD];
  logic [XLEN-1:0] exp_v;

  always #5 clk = ~clk;

  arch_regfile_mp #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .alloc_en    (alloc_en),
    .alloc_addr  (alloc_addr),
    .rw_conflict (rw_conflict)
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_addr = '0;
  endtask

  task automatic rd(input int p, input int a);
    rd_en[p] = 1'b1;
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic wr(input int p, input int a, input logic [XLEN-1:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = AW'(a);
    wr_data[p*XLEN +: XLEN] = d;
  endtask

  // One clock: combinational checks mid-cycle, model update, registered checks after the edge.
  task automatic step();
    logic [XLEN-1:0] nq [NRD];
    logic conf, hit;
    int ra, wa;
    logic [XLEN-1:0] hv;
    @(negedge clk);
    conf = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      ra = int'(rd_addr[i*AW +: AW]);
      chk($sformatf("rd_busy%0d", i), XLEN'(rd_busy[i]), XLEN'(ra != 0 && m_busy[ra]));
      for (int j = 0; j < NWR; j++)
        if (rd_en[i] && wr_en[j] && ra != 0 && ra == int'(wr_addr[j*AW +: AW])) conf = 1'b1;
    end
`ifdef REGFILE_WR_BYPASS_EN
    chk("rw_conflict", XLEN'(rw_conflict), '0);
`else
    chk("rw_conflict", XLEN'(rw_conflict), XLEN'(conf));
`endif
    if (reset) begin
      for (int k = 0; k < NREGS; k++) begin m_mem[k] = '0; m_busy[k] = 1'b0; end
      for (int i = 0; i < NRD; i++) m_rdq[i] = '0;
    end else begin
      for (int i = 0; i < NRD; i++) begin
        nq[i] = m_rdq[i];
        ra = int'(rd_addr[i*AW +: AW]);
        hit = 1'b0; hv = '0;
        for (int j = 0; j < NWR; j++)
          if (wr_en[j] && ra == int'(wr_addr[j*AW +: AW])) begin hit = 1'b1; hv = wr_data[j*XLEN +: XLEN]; end
        if (rd_en[i]) begin
          if (ra == 0)  nq[i] = '0;
          else if (hit) begin
`ifdef REGFILE_WR_BYPASS_EN
            nq[i] = hv;
`endif
          end
          else          nq[i] = m_mem[ra];
        end
      end
      for (int i = 0; i < NRD; i++) m_rdq[i] = nq[i];
      for (int j = 0; j < NWR; j++) begin
        wa = int'(wr_addr[j*AW +: AW]);
        if (wr_en[j]) begin
          if (wa != 0) m_mem[wa] = wr_data[j*XLEN +: XLEN];
          m_busy[wa] = 1'b0;
        end
      end
      if (alloc_en && alloc_addr != '0) m_busy[int'(alloc_addr)] = 1'b1;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NRD; i++)
      chk($sformatf("rd_data%0d", i), rd_data[i*XLEN +: XLEN], m_rdq[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NREGS; k++) begin m_mem[k] = '0; m_busy[k] = 1'b0; end
    for (int i = 0; i < NRD; i++) m_rdq[i] = '0;
    idle();
    reset = 1'b1;
    #1;
    step();
    step();
    chk("reset_rd_data", rd_data[XLEN-1:0] | rd_data[2*XLEN-1:XLEN], '0);
    reset = 1'b0;

    // Read every address on both ports after reset.
    for (int a = 0; a < NREGS; a++) begin
      idle(); rd(0, a); rd(1, NREGS - 1 - a); step();
    end

    idle(); wr(0, 5, 32'hDEADBEEF); step();
    idle(); rd(0, 5); step();
    chk("t2_rd5", rd_data[XLEN-1:0], 32'hDEADBEEF);
    idle(); wr(0, 0, 32'h00001234); step();
    idle(); rd(0, 0); step();
    chk("t2_rd0", rd_data[XLEN-1:0], '0);

    idle(); wr(0, 10, 32'hCAFE0001); rd(1, 10);
    #1;
`ifdef REGFILE_WR_BYPASS_EN
    chk("t3_conflict", XLEN'(rw_conflict), '0);
    exp_v = 32'hCAFE0001;
`else
    chk("t3_conflict", XLEN'(rw_conflict), 32'd1);
    exp_v = m_rdq[1];
`endif
    step();
    chk("t3_rd1", rd_data[2*XLEN-1:XLEN], exp_v);

    idle(); wr(0, 7, 32'h1111); wr(1, 7, 32'h2222); step();
    idle(); rd(0, 7); step();
    chk("t4_rd7", rd_data[XLEN-1:0], 32'h2222);

    idle(); alloc_en = 1'b1; alloc_addr = 5'd3; step();
    idle(); rd(0, 3); #1 chk("t5_busy_alloc", XLEN'(rd_busy[0]), 32'd1); step();
    idle(); rd(0, 3); wr(0, 3, 32'h33); alloc_en = 1'b1; alloc_addr = 5'd3; step();
    idle(); rd(0, 3); #1 chk("t5_busy_realloc", XLEN'(rd_busy[0]), 32'd1);
    wr(1, 3, 32'h34); step();
    idle(); rd(0, 3); #1 chk("t5_busy_clear", XLEN'(rd_busy[0]), '0); step();

    idle(); wr(0, 9, 32'hABCD0009); step();
    idle(); alloc_en = 1'b1; alloc_addr = 5'd9; wr(1, 9, 32'h9999); rd(0, 9); reset = 1'b1; step();
    reset = 1'b0;
    idle(); rd(0, 9); rd(1, 5); #1 chk("t6_busy", XLEN'(rd_busy[0]), '0); step();
    chk("t6_rd9", rd_data[XLEN-1:0], '0);
    chk("t6_rd5", rd_data[2*XLEN-1:XLEN], '0);

    // Random traffic biased toward a few low addresses to provoke collisions.
    for (int n = 0; n < 3000; n++) begin
      idle();
      reset = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NRD; i++)
        if ($urandom_range(0, 3) != 0) rd(i, $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      for (int j = 0; j < NWR; j++)
        if ($urandom_range(0, 2) == 0) wr(j, $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31), $urandom);
      if ($urandom_range(0, 2) == 0) begin
        alloc_en = 1'b1;
        alloc_addr = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      end
      step();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
